// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, ALU ops,
// controller states and datapath mux selects.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_RS1   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MEM    = 2'b01,
        RES_ALU    = 2'b10,
        RES_IMM    = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } cause_e;

    function automatic imm_src_e imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 to an ALU operation; subtract only exists for R-type,
// while the arithmetic-shift bit applies to both R-type and immediate shifts.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (funct3_i)
            3'b000:  alu_ctrl_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl_o = ALU_SLL;
            3'b010:  alu_ctrl_o = ALU_SLT;
            3'b011:  alu_ctrl_o = ALU_SLTU;
            3'b100:  alu_ctrl_o = ALU_XOR;
            3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl_o = ALU_OR;
            3'b111:  alu_ctrl_o = ALU_AND;
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// traps on illegal opcodes or memory timeouts and counts retired instructions.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       op_code_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             adr_src_o,
    output logic             pc_wr_en_o,
    output logic             ir_wr_en_o,
    output logic             reg_wr_en_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_ctrl_o,
    output logic [1:0]       result_src_o,
    output logic [2:0]       imm_src_o,
    output logic             trap_o,
    output logic [1:0]       cause_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  retired_q;
    logic              retire;
    logic              timeout_hit;
    logic              pc_en, ir_en, reg_en;
    logic [3:0]        alu_dec;

    alu_decoder u_alu_dec (
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .is_rtype_i (state_q == S_EXECR),
        .alu_ctrl_o (alu_dec)
    );

    // A transfer in the same cycle always beats the timeout.
    assign timeout_hit = (TIMEOUT != 0) && !mem_ready_i && (wait_q == WAIT_W'(TIMEOUT))
                         && (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE});

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        adr_src_o    = 1'b0;
        pc_en        = 1'b0;
        ir_en        = 1'b0;
        reg_en       = 1'b0;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        alu_ctrl_o   = ALU_ADD;
        result_src_o = RES_ALUOUT;
        imm_src_o    = IMM_I;
        trap_o       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                if (mem_ready_i) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    mem_req_o = 1'b0;
                    state_d   = S_TRAP;
                    cause_d   = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                imm_src_o   = imm_src_of(op_code_i);
                case (op_code_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    OP_BRANCH: begin
                        if (funct3_i[2:1] == 2'b00) begin
                            state_d = S_BRANCH;
                        end else begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                state_d     = (op_code_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    mem_req_o = 1'b0;
                    state_d   = S_TRAP;
                    cause_d   = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                result_src_o = RES_MEM;
                reg_en       = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    mem_req_o = 1'b0;
                    state_d   = S_TRAP;
                    cause_d   = CAUSE_TIMEOUT;
                end
            end
            S_EXECR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_ctrl_o  = alu_dec;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_ctrl_o  = alu_dec;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_o = RES_ALUOUT;
                reg_en       = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_RS2;
                alu_ctrl_o   = ALU_SUB;
                result_src_o = RES_ALUOUT;
                // funct3[0] flips the sense: BEQ takes on zero, BNE on non-zero.
                pc_en        = zero_i ^ funct3_i[0];
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_o  = SRC_A_OLDPC;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALUOUT;
                pc_en        = 1'b1;
                state_d      = S_ALUWB;
            end
            S_LUI: begin
                result_src_o = RES_IMM;
                reg_en       = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                trap_o = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // The register file and PC must never see a write while reset is held.
    assign pc_wr_en_o  = pc_en  & ~rst_i;
    assign ir_wr_en_o  = ir_en  & ~rst_i;
    assign reg_wr_en_o = reg_en & ~rst_i;
    assign cause_o     = cause_q;
    assign retired_o   = retired_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= '0;
        end else if (state_d != state_q) begin
            wait_q <= '0;
        end else if ((TIMEOUT != 0) && mem_req_o && !mem_ready_i) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_q <= '0;
        end else if (retire && !(&retired_q)) begin
            retired_q <= retired_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level phase-list model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_multicycle_controller;

    localparam int TO = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    op;
    logic [2:0]    f3;
    logic          f7;
    logic          zero;
    logic          ready;
    logic          mem_req_o, mem_we_o, adr_src_o, pc_wr_en_o, ir_wr_en_o, reg_wr_en_o;
    logic [1:0]    alu_src_a_o, alu_src_b_o, result_src_o, cause_o;
    logic [3:0]    alu_ctrl_o;
    logic [2:0]    imm_src_o;
    logic          trap_o;
    logic [CW-1:0] retired_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .op_code_i(op), .funct3_i(f3), .funct7b5_i(f7),
        .zero_i(zero), .mem_ready_i(ready), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .adr_src_o(adr_src_o), .pc_wr_en_o(pc_wr_en_o), .ir_wr_en_o(ir_wr_en_o),
        .reg_wr_en_o(reg_wr_en_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_ctrl_o(alu_ctrl_o), .result_src_o(result_src_o), .imm_src_o(imm_src_o),
        .trap_o(trap_o), .cause_o(cause_o), .retired_o(retired_o)
    );

    // Model: each instruction is a list of phases; memory phases linger until ready.
    typedef enum int {M_F, M_D, M_MA, M_MR, M_MWB, M_MW, M_XR, M_XI, M_AWB,
                      M_BR, M_J, M_LUI, M_T} mph_e;
    mph_e q[$];
    int   waits, m_cause, m_ret;

    function automatic bit is_mem(mph_e p);
        return p == M_F || p == M_MR || p == M_MW;
    endfunction

    function automatic bit tmo(mph_e p);
        return is_mem(p) && waits == TO && !ready;
    endfunction

    function automatic logic [3:0] alu_of(bit is_r);
        case (f3)
            3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd6;
            3'd2: return 4'd5;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd8 : 4'd7;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [2:0] imm_of();
        case (op)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0110111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic logic [25:0] exp_vec(mph_e p);
        logic mreq = 0, we = 0, adr = 0, pc = 0, ir = 0, rw = 0, trp = 0;
        logic [1:0] a = 0, b = 0, rs = 0;
        logic [3:0] alu = 0;
        logic [2:0] imm = 0;
        logic [1:0] c = m_cause[1:0];
        logic [3:0] r = m_ret[3:0];
        case (p)
            M_F:   begin mreq = 1; b = 2; rs = 2; pc = ready; ir = ready; end
            M_D:   begin a = 1; b = 1; imm = imm_of(); end
            M_MA:  begin a = 2; b = 1; end
            M_MR:  begin mreq = 1; adr = 1; end
            M_MWB: begin rs = 1; rw = 1; end
            M_MW:  begin mreq = 1; we = 1; adr = 1; end
            M_XR:  begin a = 2; alu = alu_of(1); end
            M_XI:  begin a = 2; b = 1; alu = alu_of(0); end
            M_AWB: rw = 1;
            M_BR:  begin a = 2; alu = 1; pc = zero ^ f3[0]; end
            M_J:   begin a = 1; b = 2; pc = 1; end
            M_LUI: begin rs = 3; rw = 1; end
            default: trp = 1;
        endcase
        if (tmo(p)) mreq = 0;
        if (rst) begin pc = 0; ir = 0; rw = 0; end
        return {mreq, we, adr, pc, ir, rw, a, b, alu, rs, imm, trp, c, r};
    endfunction

    task automatic m_reset();
        q.delete(); q.push_back(M_F);
        waits = 0; m_cause = 0; m_ret = 0;
    endtask

    task automatic plan();
        q.delete();
        case (op)
            7'b0000011: begin q.push_back(M_MA); q.push_back(M_MR); q.push_back(M_MWB); end
            7'b0100011: begin q.push_back(M_MA); q.push_back(M_MW); end
            7'b0110011: begin q.push_back(M_XR); q.push_back(M_AWB); end
            7'b0010011: begin q.push_back(M_XI); q.push_back(M_AWB); end
            7'b1101111: begin q.push_back(M_J);  q.push_back(M_AWB); end
            7'b0110111: q.push_back(M_LUI);
            7'b1100011: if (f3 < 2) q.push_back(M_BR);
                        else begin q.push_back(M_T); m_cause = 1; end
            default:    begin q.push_back(M_T); m_cause = 1; end
        endcase
    endtask

    task automatic m_adv();
        mph_e p;
        if (rst) return;
        p = q[0];
        if (p == M_T) return;
        if (tmo(p)) begin q.delete(); q.push_back(M_T); m_cause = 2; waits = 0; return; end
        if (is_mem(p) && !ready) begin waits++; return; end
        waits = 0;
        if (p == M_F) begin q.delete(); q.push_back(M_D); end
        else if (p == M_D) plan();
        else begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                if (m_ret < (1 << CW) - 1) m_ret++;
                q.push_back(M_F);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [25:0] act, want;
            act  = {mem_req_o, mem_we_o, adr_src_o, pc_wr_en_o, ir_wr_en_o, reg_wr_en_o,
                    alu_src_a_o, alu_src_b_o, alu_ctrl_o, result_src_o, imm_src_o,
                    trap_o, cause_o, retired_o};
            want = exp_vec(q[0]);
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL cycle_model t=%0t phase=%0d got=%h want=%h", $time, q[0], act, want);
            end
        end
    end

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_adv();
        #1;
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] fn3, input logic b5);
        op = o; f3 = fn3; f7 = b5;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_ir();
        case ($urandom_range(0, 9))
            0, 8: set_ir(7'b0110011, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            1, 9: set_ir(7'b0010011, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            2:    set_ir(7'b0000011, 3'd2, 1'b0);
            3:    set_ir(7'b0100011, 3'd2, 1'b0);
            4:    set_ir(7'b1100011, 3'($urandom_range(0, 2)), 1'b0);
            5:    set_ir(7'b1101111, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            6:    set_ir(7'b0110111, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            default: set_ir(7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
        endcase
    endtask

    initial begin
        logic [31:0] add_ir;
        logic [3:0]  wb;
        int          n, wb_at, trap_cnt;
        bit          rdy_pat [7];

        add_ir = 32'h002081B3;
        rst = 1'b1; ready = 1'b0; zero = 1'b0;
        set_ir(add_ir[6:0], add_ir[14:12], add_ir[30]);
        m_reset();
        chk_en = 1;

        // Reset state, and no enable pulses while reset is held even with ready high.
        #2;
        check("rst_mem_req", mem_req_o, 1);
        check("rst_trap", trap_o, 0);
        check("rst_cause", cause_o, 0);
        check("rst_retired", retired_o, 0);
        ready = 1'b1;
        #1;
        check("rst_ir_en_gated", ir_wr_en_o, 0);
        check("rst_pc_en_gated", pc_wr_en_o, 0);
        tick();
        rst = 1'b0;

        // ADD x3,x1,x2 with ready always 1: writeback in the 4th cycle.
        wb = '0;
        for (int c = 0; c < 4; c++) begin #2; wb[c] = reg_wr_en_o; tick(); end
        check("add_wb_pattern", wb, 4'b1000);
        #2 check("add_retired", retired_o, 1);

        // LW with 2 wait cycles in MEMREAD: 7 cycles, 3 cycles of addressed request.
        set_ir(7'b0000011, 3'd2, 1'b0);
        rdy_pat = '{1, 1, 1, 0, 0, 1, 1};
        n = 0; wb_at = -1;
        for (int c = 0; c < 7; c++) begin
            ready = rdy_pat[c];
            #2;
            if (mem_req_o && adr_src_o) n++;
            if (reg_wr_en_o) wb_at = c;
            tick();
        end
        check("lw_req_adr_cycles", n, 3);
        check("lw_wb_cycle", wb_at, 6);
        ready = 1'b1;
        #2 check("lw_retired", retired_o, 2);

        // BEQ / BNE with zero=1.
        zero = 1'b1;
        set_ir(7'b1100011, 3'd0, 1'b0);
        tick(); tick(); #2 check("beq_taken", pc_wr_en_o, 1); tick();
        set_ir(7'b1100011, 3'd1, 1'b0);
        tick(); tick(); #2 check("bne_not_taken", pc_wr_en_o, 0); tick();
        #2 check("branch_retired", retired_o, 4);

        // Illegal opcode traps after DECODE and stays quiet.
        set_ir(7'h7F, 3'd0, 1'b0);
        tick(); tick();
        #2 check("ill_trap", trap_o, 1);
        check("ill_cause", cause_o, 1);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (mem_req_o || mem_we_o || pc_wr_en_o || ir_wr_en_o || reg_wr_en_o || !trap_o) n++;
            tick();
        end
        check("ill_quiet_cycles", n, 0);
        do_reset();
        #2 check("ill_reset_clears", trap_o, 0);

        // Timeout with ready held low in FETCH.
        ready = 1'b0;
        tick(); tick(); tick();
        #2 check("tmo_req_drops", mem_req_o, 0);
        check("tmo_not_yet", trap_o, 0);
        tick();
        #2 check("tmo_trap", trap_o, 1);
        check("tmo_cause", cause_o, 2);
        do_reset();
        ready = 1'b0;
        tick(); tick(); tick();
        ready = 1'b1;
        #2 check("tmo_race_ir_en", ir_wr_en_o, 1);
        check("tmo_race_req", mem_req_o, 1);
        tick();
        #2 check("tmo_race_no_trap", trap_o, 0);

        // 17 back-to-back LUIs saturate a 4-bit counter.
        do_reset();
        set_ir(7'b0110111, 3'd0, 1'b0);
        ready = 1'b1;
        repeat (42) tick();
        #2 check("lui_retired_14", retired_o, 14);
        repeat (9) tick();
        #2 check("lui_saturated", retired_o, 15);

        // Asynchronous reset in the middle of EXECR.
        do_reset();
        set_ir(add_ir[6:0], add_ir[14:12], add_ir[30]);
        repeat (6) tick();
        #1 check("mid_execr_a", alu_src_a_o, 2);
        check("mid_retired_before", retired_o, 1);
        rst = 1'b1;
        m_reset();
        #1 check("arst_mem_req", mem_req_o, 1);
        check("arst_src_a", alu_src_a_o, 0);
        check("arst_src_b", alu_src_b_o, 2);
        check("arst_result", result_src_o, 2);
        check("arst_ir_en", ir_wr_en_o, 0);
        check("arst_retired", retired_o, 0);
        tick();
        rst = 1'b0;

        // Randomized traffic against the model.
        trap_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            zero  = 1'($urandom_range(0, 1));
            if (q[0] == M_F) rand_ir();
            if (q[0] == M_T) begin
                trap_cnt++;
                if (trap_cnt > 2) begin trap_cnt = 0; do_reset(); continue; end
            end else if ($urandom_range(0, 299) == 0) begin
                #1;
                do_reset();
                continue;
            end
            tick();
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
